// File: rtl/qpu_exu_oitf_pkg.sv
// Shared sizing for the QPU execution unit's outstanding instruction track FIFO.
package qpu_exu_oitf_pkg;

  localparam int unsigned QPU_RFIDX_REAL_WIDTH = 5;
  localparam int unsigned QPU_OITF_DEPTH       = 4;
  localparam int unsigned QPU_OITF_PTR_W       = $clog2(QPU_OITF_DEPTH);

endpackage

// File: rtl/qpu_exu_oitf_if.sv
// Dispatch, hazard-check and long-pipe retire signals of the OITF.
interface qpu_exu_oitf_if
  import qpu_exu_oitf_pkg::*;
#(
  parameter int unsigned RFIDX_W = QPU_RFIDX_REAL_WIDTH,
  parameter int unsigned PTR_W   = QPU_OITF_PTR_W
);

  logic               dis_ena;
  logic               dis_ready;
  logic               disp_i_rdwen;
  logic [RFIDX_W-1:0] disp_i_rdidx;
  logic               disp_i_rs1en;
  logic               disp_i_rs2en;
  logic [RFIDX_W-1:0] disp_i_rs1idx;
  logic [RFIDX_W-1:0] disp_i_rs2idx;
  logic [PTR_W-1:0]   dis_ptr;
  logic               oitfrd_match_disprs1;
  logic               oitfrd_match_disprs2;
  logic               oitfrd_match_disprd;
  logic               ret_ena;
  logic [PTR_W-1:0]   ret_ptr;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic               ret_rdwen;
  logic               oitf_empty;

  modport master (
    output dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_rs1en, disp_i_rs2en,
           disp_i_rs1idx, disp_i_rs2idx, ret_ena,
    input  dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprd, ret_ptr, ret_rdidx, ret_rdwen, oitf_empty
  );

  modport slave (
    input  dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_rs1en, disp_i_rs2en,
           disp_i_rs1idx, disp_i_rs2idx, ret_ena,
    output dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprd, ret_ptr, ret_rdidx, ret_rdwen, oitf_empty
  );

endinterface

// File: rtl/qpu_wrap_ptr.sv
// Modulo-DEPTH pointer with a wrap flag that toggles on every DEPTH-1 -> 0 step.
module qpu_wrap_ptr #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [PTR_W-1:0] ptr,
  output logic             flg
);

  logic [PTR_W-1:0] ptr_q;
  logic             flg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      flg_q <= 1'b0;
    end else if (ena) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
        ptr_q <= '0;
        flg_q <= ~flg_q;
      end else begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  assign ptr = ptr_q;
  assign flg = flg_q;

endmodule

// File: rtl/qpu_exu_oitf.sv
// Outstanding instruction track FIFO: program-order long-pipe destinations plus
// a combinational RAW/WAW hazard check for dispatch.
module qpu_exu_oitf
  import qpu_exu_oitf_pkg::*;
#(
  parameter int unsigned DEPTH   = QPU_OITF_DEPTH,
  parameter int unsigned RFIDX_W = QPU_RFIDX_REAL_WIDTH,
  parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst,
  qpu_exu_oitf_if.slave  oitf
);

  logic [PTR_W-1:0]   alc_ptr, rtr_ptr;
  logic               alc_flg, rtr_flg;
  logic               empty, full, alc_ena, rtr_ena;
  logic [DEPTH-1:0]   vld_q;
  logic [DEPTH-1:0]   rdwen_q;
  logic [RFIDX_W-1:0] rdidx_q [DEPTH];
  logic [DEPTH-1:0]   hit_rs1, hit_rs2, hit_rd;

  // Full/empty come from pointers and wrap flags only; no occupancy counter.
  assign empty   = (alc_ptr == rtr_ptr) && (alc_flg == rtr_flg);
  assign full    = (alc_ptr == rtr_ptr) && (alc_flg != rtr_flg);
  assign alc_ena = oitf.dis_ena & ~full;
  assign rtr_ena = oitf.ret_ena & ~empty;

  qpu_wrap_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_alc_ptr (
    .clk (clk),
    .rst (rst),
    .ena (alc_ena),
    .ptr (alc_ptr),
    .flg (alc_flg)
  );

  qpu_wrap_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rtr_ptr (
    .clk (clk),
    .rst (rst),
    .ena (rtr_ena),
    .ptr (rtr_ptr),
    .flg (rtr_flg)
  );

  // Allocate and retire never hit the same slot: that needs full or empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (alc_ena && (alc_ptr == PTR_W'(i))) begin
          vld_q[i] <= 1'b1;
        end else if (rtr_ena && (rtr_ptr == PTR_W'(i))) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Payload is left unreset; vld_q qualifies every use of it.
  always_ff @(posedge clk) begin
    if (!rst && alc_ena) begin
      rdidx_q[alc_ptr] <= oitf.disp_i_rdidx;
      rdwen_q[alc_ptr] <= oitf.disp_i_rdwen;
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_match
    assign hit_rs1[g] = vld_q[g] & rdwen_q[g] & (rdidx_q[g] == oitf.disp_i_rs1idx);
    assign hit_rs2[g] = vld_q[g] & rdwen_q[g] & (rdidx_q[g] == oitf.disp_i_rs2idx);
    assign hit_rd[g]  = vld_q[g] & rdwen_q[g] & (rdidx_q[g] == oitf.disp_i_rdidx);
  end

  assign oitf.oitfrd_match_disprs1 = oitf.disp_i_rs1en & (|hit_rs1);
  assign oitf.oitfrd_match_disprs2 = oitf.disp_i_rs2en & (|hit_rs2);
  assign oitf.oitfrd_match_disprd  = oitf.disp_i_rdwen & (|hit_rd);

  assign oitf.dis_ready  = ~full;
  assign oitf.dis_ptr    = alc_ptr;
  assign oitf.ret_ptr    = rtr_ptr;
  assign oitf.ret_rdidx  = rdidx_q[rtr_ptr];
  assign oitf.ret_rdwen  = rdwen_q[rtr_ptr] & ~empty;
  assign oitf.oitf_empty = empty;

endmodule

// File: doc/qpu_exu_oitf.md
# qpu_exu_oitf

Outstanding Instruction Track FIFO for the QPU execution unit's long pipe. It records the destination register of every dispatched long-pipe instruction (LSU loads) in program order. It presents the oldest entry to the long-pipe write-back arbiter and retires that entry on the arbiter's handshake. It also gives dispatch a combinational RAW/WAW hazard check against all outstanding destinations.

## Interface
Parameters:
- `DEPTH`, default `QPU_OITF_DEPTH` (4): number of entries. Power of two, ≥2.
- `RFIDX_W`, default `QPU_RFIDX_REAL_WIDTH`: register-index width.
- `PTR_W`, default log2(DEPTH): entry-pointer width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `dis_ena` in 1: dispatch allocates an entry this cycle. Only honoured when `dis_ready`=1.
- `dis_ready` out 1: not full.
- `disp_i_rdwen` in 1: the instruction writes a destination register.
- `disp_i_rdidx` in RFIDX_W: destination index.
- `disp_i_rs1en`, `disp_i_rs2en` in 1: source operand valid.
- `disp_i_rs1idx`, `disp_i_rs2idx` in RFIDX_W: source indices.
- `dis_ptr` out PTR_W: index of the entry allocated by the current `dis_ena`.
- `oitfrd_match_disprs1`, `oitfrd_match_disprs2`, `oitfrd_match_disprd` out 1: hazard flags.
- `ret_ena` in 1: retire the oldest entry (driven by long-pipe write-back `oitf_ret_ena`).
- `ret_ptr` out PTR_W: index of the oldest entry.
- `ret_rdidx` out RFIDX_W: rdidx of the oldest entry.
- `ret_rdwen` out 1: rdwen of the oldest entry. Forced to 0 when empty.
- `oitf_empty` out 1: no outstanding entries.

## Operation
- Circular buffer. Each entry holds `vld`, `rdwen`, `rdidx`.
- Two pointers: `alc_ptr` (allocate) and `rtr_ptr` (retire). Each has a wrap flag (`alc_flg`, `rtr_flg`).
- `empty` = (`alc_ptr`==`rtr_ptr`) & (`alc_flg`==`rtr_flg`). `full` = pointers equal and flags differ.
- Allocate: `dis_ena` & ~full. Write the entry at `alc_ptr`, set its `vld`, increment `alc_ptr`. On wrap DEPTH-1→0, toggle `alc_flg`.
- Retire: `ret_ena` & ~empty. Clear `vld` at `rtr_ptr`, increment `rtr_ptr` with the same wrap rule.
- `ret_ena` while empty is ignored. This is a protocol violation and the bench asserts it never occurs.
- Simultaneous allocate and retire: both happen. Occupancy is unchanged.
  - When full, `dis_ready`=0 even if `ret_ena`=1. There is no full-bypass.
  - When empty, only the allocate takes effect.
- `dis_ptr` = `alc_ptr`. `ret_ptr` = `rtr_ptr`. `ret_rdidx`/`ret_rdwen` are read from the entry at `rtr_ptr`.
- Hazard flags, combinational OR over all entries:
  - `oitfrd_match_disprs1` = OR over entries of (`vld` & `rdwen` & `rdidx`==`disp_i_rs1idx`), gated by `disp_i_rs1en`.
  - `oitfrd_match_disprs2`: same, using rs2.
  - `oitfrd_match_disprd`: same, using `disp_i_rdidx` and gated by `disp_i_rdwen`.
- Width rule: pointer arithmetic is modulo DEPTH. No occupancy counter is kept; full and empty come from the pointers and flags only.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge):
  - `alc_ptr`, `rtr_ptr`, both flags and all `vld` bits go to 0.
  - Entry `rdidx`/`rdwen` storage is not reset.
  - Post-reset outputs: `dis_ready`=1, `oitf_empty`=1, `ret_rdwen`=0, `dis_ptr`=0, `ret_ptr`=0, all match flags 0.
- Reset mid-operation discards all outstanding entries. Reset overrides a same-cycle `dis_ena` or `ret_ena`.
- An allocate at edge N is visible from N+1: in `oitf_empty`, `ret_*` and the match flags. It is never visible in the allocating cycle.
- A retire at edge N clears that entry's match contribution from N+1.
- `dis_ready`, `oitf_empty`, `ret_*` and the match flags depend only on registered state and dispatch inputs. None depends on `ret_ena` or `dis_ena`, so no combinational loop forms with the write-back arbiter.
- Retire latency: an entry can retire one cycle after allocation at the earliest. Throughput is 1 allocate + 1 retire per cycle.

## Structure
- Shared defines: `QPU_OITF_DEPTH` and derived `QPU_OITF_PTR_W`. Reuse the existing `QPU_RFIDX_REAL_WIDTH`.
- One natural sub-module, `qpu_wrap_ptr`: a PTR_W counter with wrap flag, enable and synchronous reset. It is instantiated twice, for allocate and retire.
- Entry array and match logic stay inline in a generate loop.
- Expected size is about 150–250 lines.

## Test plan
- Reset then idle: `oitf_empty`=1, `dis_ready`=1, `ret_rdwen`=0, all matches 0 for any rs index.
- Four allocates (rd=3,5,7,9, rdwen=1), no retire:
  - `dis_ready`=0 after the 4th.
  - A 5th `dis_ena` is ignored.
  - `ret_rdidx`=3.
- Retire all four in order: `ret_rdidx` sequence 3,5,7,9, then `oitf_empty`=1 and `ret_ptr`=0 with `rtr_flg` toggled.
- Allocate rd=5 with rdwen=1, then dispatch rs1=5/rs1en=1, rs2=5/rs2en=0 and rd=5 with rdwen=1:
  - rs1 match=1, rs2 match=0, rd match=1.
  - After the retire, all three are 0 the next cycle.
- Steady state at occupancy 2 with allocate+retire every cycle for 10 cycles: occupancy stays 2, pointers wrap correctly and FIFO order is preserved.
- Allocate 3 entries, assert `rst` together with `dis_ena`: next cycle empty, all `vld`=0, no stale match on rd=3.
